// File: rtl/rx_lane_aligner_if.sv
// Bundle of serial inputs and word-level outputs of the multi-lane RX aligner.
// The master side drives the serial lanes; the slave side is the aligner.
interface rx_lane_aligner_if #(
  parameter int LANES = 2
);
  logic [LANES-1:0]   serial_data;
  logic [LANES-1:0]   active;
  logic [8*LANES-1:0] data_out;
  logic [LANES-1:0]   valid_out;
  logic [8*LANES-1:0] data_final;
  logic               valid_final;
  logic               overflow_err;

  modport master (
    output serial_data,
    input  active, data_out, valid_out, data_final, valid_final, overflow_err
  );

  modport slave (
    input  serial_data,
    output active, data_out, valid_out, data_final, valid_final, overflow_err
  );
endinterface

// File: rtl/rx_lane_aligner.sv
// Multi-lane serial receiver: per-lane MSB-first deserialiser with comma
// alignment and lock, followed by bonding of all lanes into one word.
// Bonding tolerates up to 7 bits of inter-lane skew.
module rx_lane_aligner #(
  parameter int         LANES    = 2,
  parameter logic [7:0] COMMA    = 8'hBC,
  parameter int         LOCK_CNT = 4
) (
  input logic              clk_32f,
  input logic              reset,
  rx_lane_aligner_if.slave bus
);
  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} lane_state_t;

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);

  logic [LANES-1:0]   ready;       // lane has a byte for the next bonded word
  logic [LANES-1:0]   lane_ovf;    // lane delivered while its hold was still full
  logic [8*LANES-1:0] final_word;  // bonded word as it would be emitted now
  logic               emit;

  logic [8*LANES-1:0] data_final_reg;
  logic               valid_final_reg;
  logic               overflow_reg;

  // A bonded word goes out as soon as every lane has a byte, counting
  // lanes that deliver in this very cycle.
  assign emit = &ready;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    lane_state_t state_reg, state_next;
    logic [7:0]  sh_reg;
    logic [2:0]  bitcnt_reg, bitcnt_next;
    logic [3:0]  ccnt_reg, ccnt_next;
    logic        deliver_next;
    logic [7:0]  data_out_reg;
    logic        valid_out_reg;
    logic [7:0]  hold_reg;
    logic        pending_reg;

    // Shift one serial bit into the lane, MSB first.
    always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) sh_reg <= '0;
      else       sh_reg <= {sh_reg[6:0], bus.serial_data[gi]};
    end

    // Lane FSM state, bit counter and comma counter.
    always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
        state_reg  <= SEARCH;
        bitcnt_reg <= '0;
        ccnt_reg   <= '0;
      end else begin
        state_reg  <= state_next;
        bitcnt_reg <= bitcnt_next;
        ccnt_reg   <= ccnt_next;
      end
    end

    // Hunt for a comma, count aligned commas to lock, then deliver bytes.
    // A byte is judged in the cycle where bitcnt is 7, i.e. once sh holds
    // all eight bits of the byte that followed the previous boundary.
    always_comb begin
      state_next   = state_reg;
      bitcnt_next  = bitcnt_reg;
      ccnt_next    = ccnt_reg;
      deliver_next = 1'b0;
      case (state_reg)
        SEARCH: begin
          if (sh_reg == COMMA) begin
            bitcnt_next = 3'd0;
            ccnt_next   = 4'd1;
            state_next  = (LOCK_CNT == 1) ? ACTIVE : ALIGN;
          end
        end
        ALIGN: begin
          bitcnt_next = bitcnt_reg + 3'd1;
          if (bitcnt_reg == 3'd7) begin
            if (sh_reg == COMMA) begin
              ccnt_next = ccnt_reg + 4'd1;
              if (ccnt_next == LOCK_TARGET) state_next = ACTIVE;
            end else begin
              ccnt_next  = 4'd0;
              state_next = SEARCH;
            end
          end
        end
        ACTIVE: begin
          bitcnt_next = bitcnt_reg + 3'd1;
          // Commas on a locked lane are idle fill and are dropped.
          if (bitcnt_reg == 3'd7 && sh_reg != COMMA) deliver_next = 1'b1;
        end
        default: state_next = SEARCH;
      endcase
    end

    // Publish each delivered data byte with a one-cycle valid pulse.
    always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
        data_out_reg  <= '0;
        valid_out_reg <= 1'b0;
      end else begin
        valid_out_reg <= deliver_next;
        if (deliver_next) data_out_reg <= sh_reg;
      end
    end

    // Hold the lane's byte until the rest of the lanes catch up. A byte
    // arriving on the emit cycle of an already-held byte queues for the
    // next word; one arriving while held without an emit is dropped.
    always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
        hold_reg    <= '0;
        pending_reg <= 1'b0;
      end else if (emit) begin
        pending_reg <= pending_reg & deliver_next;
        if (pending_reg && deliver_next) hold_reg <= sh_reg;
      end else if (deliver_next && !pending_reg) begin
        hold_reg    <= sh_reg;
        pending_reg <= 1'b1;
      end
    end

    assign ready[gi]              = pending_reg | deliver_next;
    assign lane_ovf[gi]           = deliver_next & pending_reg & ~emit;
    assign final_word[8*gi +: 8]  = pending_reg ? hold_reg : sh_reg;
    assign bus.active[gi]         = (state_reg == ACTIVE);
    assign bus.valid_out[gi]      = valid_out_reg;
    assign bus.data_out[8*gi +: 8] = data_out_reg;
  end

  // Register the bonded word and keep the skew-overflow flag sticky.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      data_final_reg  <= '0;
      valid_final_reg <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      valid_final_reg <= emit;
      if (emit)      data_final_reg <= final_word;
      if (|lane_ovf) overflow_reg   <= 1'b1;
    end
  end

  assign bus.data_final   = data_final_reg;
  assign bus.valid_final  = valid_final_reg;
  assign bus.overflow_err = overflow_reg;
endmodule

// File: tb/tb_rx_lane_aligner.sv
// Directed bench for rx_lane_aligner: per-lane bit queues feed the serial
// inputs, expected lane bytes and bonded words wait in scoreboard queues
// and are popped when the matching valid pulse is seen.
module tb_rx_lane_aligner;
  localparam int         LANES = 2;
  localparam logic [7:0] COMMA = 8'hBC;

  logic clk_32f = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int vo0_cyc = -1, vo1_cyc = -1, vf_cyc = -1;

  bit          q0[$], q1[$];
  logic [7:0]  exp0[$], exp1[$];
  logic [15:0] expf[$];

  rx_lane_aligner_if #(.LANES(LANES)) bus ();

  rx_lane_aligner #(.LANES(LANES), .COMMA(COMMA), .LOCK_CNT(4)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_bits(input int lane, input int n, input logic [7:0] v);
    for (int i = n - 1; i >= 0; i--) begin
      if (lane == 0) q0.push_back(v[i]);
      else           q1.push_back(v[i]);
    end
  endtask

  task automatic push_byte(input int lane, input logic [7:0] b);
    push_bits(lane, 8, b);
  endtask

  task automatic commas(input int lane, input int n);
    for (int i = 0; i < n; i++) push_byte(lane, COMMA);
  endtask

  task automatic data(input int lane, input logic [7:0] b);
    push_byte(lane, b);
    if (lane == 0) exp0.push_back(b);
    else           exp1.push_back(b);
  endtask

  task automatic step();
    bit b0, b1;
    @(negedge clk_32f);
    b0 = (q0.size() > 0) ? q0.pop_front() : 1'b0;
    b1 = (q1.size() > 0) ? q1.pop_front() : 1'b0;
    bus.serial_data = {b1, b0};
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int guard = 0;
    while ((q0.size() > 0 || q1.size() > 0) && guard < 2000) begin
      step();
      guard++;
    end
    chk("drain_bound", guard < 2000, 1);
    run(2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q0.delete(); q1.delete();
    exp0.delete(); exp1.delete(); expf.delete();
    bus.serial_data = '0;
    run(2);
    reset = 1'b0;
    vo0_cyc = -1; vo1_cyc = -1; vf_cyc = -1;
  endtask

  task automatic end_test(input string name);
    chk({name, "_exp0_left"}, exp0.size(), 0);
    chk({name, "_exp1_left"}, exp1.size(), 0);
    chk({name, "_expf_left"}, expf.size(), 0);
  endtask

  // Scoreboard: every valid pulse must match the oldest expected entry.
  always @(negedge clk_32f) begin
    if (reset !== 1'b1) begin
      cyc++;
      if (bus.valid_out[0]) begin
        vo0_cyc = cyc;
        chk("vo0_expected", exp0.size() > 0, 1);
        if (exp0.size() > 0) chk("data_out0", bus.data_out[7:0], exp0.pop_front());
      end
      if (bus.valid_out[1]) begin
        vo1_cyc = cyc;
        chk("vo1_expected", exp1.size() > 0, 1);
        if (exp1.size() > 0) chk("data_out1", bus.data_out[15:8], exp1.pop_front());
      end
      if (bus.valid_final) begin
        vf_cyc = cyc;
        chk("vf_expected", expf.size() > 0, 1);
        if (expf.size() > 0) chk("data_final", bus.data_final, expf.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    reset = 1'b1;
    bus.serial_data = '0;
    run(2);
    chk("rst_active", bus.active, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_valid_out", bus.valid_out, 0);
    chk("rst_data_final", bus.data_final, 0);
    chk("rst_valid_final", bus.valid_final, 0);
    chk("rst_overflow", bus.overflow_err, 0);

    // Lock on both lanes, zero skew, one data byte
    do_reset();
    commas(0, 4); commas(1, 4);
    run(32);
    data(0, 8'hA5); data(1, 8'hA5); expf.push_back(16'hA5A5);
    commas(0, 1); commas(1, 1);
    step();
    chk("t1_active_before", bus.active, 2'b00);
    step();
    chk("t1_active_lock", bus.active, 2'b11);
    drain();
    chk("t1_vf_vs_vo0", vf_cyc, vo0_cyc);
    chk("t1_vf_vs_vo1", vf_cyc, vo1_cyc);
    chk("t1_final_hold", bus.data_final, 16'hA5A5);
    chk("t1_out_hold", bus.data_out, 16'hA5A5);
    end_test("t1");

    // Lane 0 aligned at a 3-bit offset; lane 1 never locks
    do_reset();
    push_bits(0, 3, 8'b101);
    commas(0, 4);
    run(35);
    data(0, 8'h3C); commas(0, 1);
    step();
    chk("t2_active_before", bus.active, 2'b00);
    step();
    chk("t2_active_lock", bus.active, 2'b01);
    drain();
    chk("t2_no_final", vf_cyc, -1);
    chk("t2_out_hold", bus.data_out[7:0], 8'h3C);
    end_test("t2");

    // Broken comma sends the lane back to search
    do_reset();
    commas(0, 2); push_byte(0, 8'hBD); commas(0, 4);
    run(56);
    data(0, 8'h11); commas(0, 1);
    step();
    chk("t3_active_before", bus.active, 2'b00);
    step();
    chk("t3_active_lock", bus.active, 2'b01);
    drain();
    end_test("t3");

    // Lane 1 lags lane 0 by 3 bits, idle comma before data
    do_reset();
    commas(0, 5); data(0, 8'h12); commas(0, 2);
    push_bits(1, 3, 8'b000); commas(1, 5); data(1, 8'h34); commas(1, 1);
    expf.push_back(16'h3412);
    drain();
    chk("t4_skew_delay", vf_cyc - vo0_cyc, 3);
    chk("t4_vf_vs_vo1", vf_cyc, vo1_cyc);
    chk("t4_no_overflow", bus.overflow_err, 0);
    chk("t4_final_hold", bus.data_final, 16'h3412);
    end_test("t4");

    // Overflow: lane 0 delivers twice before lane 1 delivers once
    do_reset();
    commas(0, 4); data(0, 8'h01); data(0, 8'h02); commas(0, 2);
    commas(1, 6); data(1, 8'h03); commas(1, 1);
    expf.push_back(16'h0301);
    run(49);
    chk("t5_ovf_before", bus.overflow_err, 0);
    step();
    chk("t5_ovf_set", bus.overflow_err, 1);
    drain();
    chk("t5_ovf_sticky", bus.overflow_err, 1);
    chk("t5_final", bus.data_final, 16'h0301);
    end_test("t5");

    // Asynchronous reset in the middle of a data byte, then relock
    do_reset();
    commas(0, 4); commas(1, 4);
    data(0, 8'h5A); data(1, 8'h5A); expf.push_back(16'h5A5A);
    push_byte(0, 8'h77); push_byte(1, 8'h77);
    run(44);
    chk("t6_final_pre", bus.data_final, 16'h5A5A);
    chk("t6_active_pre", bus.active, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_active", bus.active, 0);
    chk("t6_async_data_out", bus.data_out, 0);
    chk("t6_async_final", bus.data_final, 0);
    chk("t6_async_valid", {bus.valid_out, bus.valid_final}, 0);
    end_test("t6a");
    do_reset();
    commas(0, 4); commas(1, 4);
    run(32);
    data(0, 8'h66); data(1, 8'h66); expf.push_back(16'h6666);
    commas(0, 1); commas(1, 1);
    step();
    chk("t6_relock_before", bus.active, 2'b00);
    step();
    chk("t6_relock", bus.active, 2'b11);
    drain();
    end_test("t6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_lane_aligner.md
# rx_lane_aligner

Parametrised multi-lane serial receiver for the PHY RX path: deserialises MSB-first bit streams on LANES independent lanes and aligns each lane to a comma byte (default 0xBC). A lane declares lock after LOCK_CNT consecutive aligned commas. Once locked, the lane delivers data bytes and drops commas as idle. The lanes are then bonded into one LANES×8-bit word, tolerating up to 7 bits of inter-lane skew. The block sits between the serial line inputs and the word-level RX logic, running entirely on the bit clock.

## Interface
- LANES, 2: number of serial lanes (1..8).
- COMMA, 8'hBC: alignment/idle byte.
- LOCK_CNT, 4: consecutive aligned commas required for lock (1..15).
- clk_32f  in  1  bit clock; all logic on its rising edge.
- reset  in  1  reset, asynchronous and active-high.
- serial_data  in  LANES  one serial bit per lane, sampled every clk_32f edge; bit i = lane i.
- active  out  LANES  per-lane lock flag.
- data_out  out  8*LANES  last data byte per lane; lane i at [8i+7:8i].
- valid_out  out  LANES  one-cycle pulse per lane when its data_out updates with a non-comma byte.
- data_final  out  8*LANES  bonded word; lane i at [8i+7:8i].
- valid_final  out  1  one-cycle pulse when data_final updates.
- overflow_err  out  1  sticky; set on a skew overflow.

## Operation
- Per-lane shift register: sh <= {sh[6:0], serial_data[i]} every edge.
- Per-lane FSM with states SEARCH, ALIGN and ACTIVE, plus a 3-bit bit counter and a 4-bit comma counter.
- SEARCH:
  - sh is compared with COMMA every cycle.
  - On a match: bitcnt <= 0, ccnt <= 1. If LOCK_CNT==1, go to ACTIVE; otherwise go to ALIGN.
- ALIGN:
  - bitcnt increments every cycle and wraps 7->0.
  - A byte is complete in the cycle where bitcnt==7; it is evaluated at that edge.
  - If the byte == COMMA: ccnt++. Reaching LOCK_CNT goes to ACTIVE.
  - If the byte != COMMA: go to SEARCH with ccnt <= 0.
- ACTIVE:
  - Each completed byte equal to COMMA is idle: no valid_out, lock kept.
  - Any other byte is data: data_out[i] <= byte, valid_out[i] <= 1 for one cycle.
  - Lock is left only via reset.
- Bonding:
  - Each lane has a hold byte and a pending flag, set when it delivers a data byte.
  - When every lane is pending, counting lanes delivering in this same cycle: data_final <= hold bytes (the new byte for lanes delivering now), valid_final pulses, and all pending flags clear.
  - A lane delivering while already pending, with no emission this cycle: the new byte is discarded and overflow_err <= 1.
  - If a lane delivers on the very cycle the set is emitted from its previous hold, the new byte becomes pending for the next set; this is not an error.
- Lanes never in ACTIVE never go pending, so valid_final stays 0 until all lanes lock.

## Timing
- Reset values: sh=0, FSM=SEARCH, bitcnt=0, ccnt=0, active=0, data_out=0, valid_out=0, data_final=0, valid_final=0, overflow_err=0, pending=0.
- Asserting reset mid-operation returns every lane to SEARCH immediately; no output pulses occur during reset.
- Comma detection is on the registered sh. If the last comma bit is sampled at edge k, the match acts at edge k+1.
- Next byte boundary: the byte whose last bit is sampled at edge k+8.
- active rises at the edge following the sample of the last bit of the LOCK_CNT-th comma.
- valid_out/data_out latency: one edge after the last bit of the byte is sampled.
- valid_final:
  - Same edge as the latest lane's valid_out in the set.
  - With zero skew, it coincides with valid_out on all lanes.
- Lane i and lane j aligned at different bit offsets bond correctly provided skew < 8 bits.
- data_out and data_final hold their value between pulses.

## Test plan
- Lock: LANES=2, both lanes send 4×0xBC, then 0xA5. active=2'b11 one cycle after the 4th comma's last bit. valid_out=2'b11 with data_out=16'hA5A5, and valid_final with data_final=16'hA5A5 on the same edge.
- Bit offset: lane 0 sends 3 junk bits 101, then 4×0xBC, then 0x3C. Lock is at the 3-bit offset and data_out[7:0]=0x3C. No false lock on junk: 0xBC only straddling the junk does not match.
- Broken comma: 2×0xBC, 0xBD, then 4×0xBC, 0x11. FSM returns to SEARCH at 0xBD. active rises only after the 4 fresh commas, then valid with 0x11.
- Skew and idle: lane 1 delayed 3 bits vs lane 0, both send 4×0xBC, 0xBC idle, 0x12/0x34.
  - No valid_out on the idle comma.
  - valid_final 3 cycles after lane 0's valid_out, data_final=16'h3412.
  - overflow_err stays 0.
- Overflow: after lock, lane 0 sends 0x01, 0x02 while lane 1 sends 0xBC, 0xBC, then 0x03. overflow_err=1 at lane 0's second byte. data_final=16'h0301, and overflow_err stays 1.
- Reset mid-ACTIVE: pulse reset during a data byte. All outputs return to 0 asynchronously; relock requires 4 new commas.
